// File: rtl/counter_pkg.sv
// counter_pkg: constants and helpers shared by the counter block.
//   LOAD_W     width of the parallel-load bus
//   UP / DOWN  encoding of the direction input
//   cnt_op_e   the control action selected for one clock edge (below reset)
//   sel_op()   resolves clr/load/en into a single action by priority
package counter_pkg;

    localparam int LOAD_W = 16;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_STEP = 2'd3
    } cnt_op_e;

    // Reset is handled directly in the register block, so only
    // clr > load > en is resolved here.
    function automatic cnt_op_e sel_op(input logic clr, input logic load, input logic en);
        cnt_op_e op;
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_if.sv
// counter_if: bundle of the counter's control inputs and count outputs.
//   master  : drives clr/en/down/load/load_val, observes count/ovf
//   slave   : the counter side
//   monitor : read-only view for checkers
// clk and rst are kept as plain ports on every user of this interface.
interface counter_if #(
    parameter int WIDTH = 16
);
    import counter_pkg::*;

    logic              clr;
    logic              en;
    logic              down;
    logic              load;
    logic [LOAD_W-1:0] load_val;
    logic [WIDTH-1:0]  count;
    logic              ovf;

    modport master (
        output clr, en, down, load, load_val,
        input  count, ovf
    );

    modport slave (
        input  clr, en, down, load, load_val,
        output count, ovf
    );

    modport monitor (
        input clr, en, down, load, load_val, count, ovf
    );

endinterface

// File: rtl/counter_chk.sv
// counter_chk: property checker bound to a counter through the monitor view.
//   clk, rst : same clock and reset as the counter
//   mon      : counter_if monitor modport
module counter_chk (
    input logic        clk,
    input logic        rst,
    counter_if.monitor mon
);

    // After a reset edge the counter is at zero with no wrap pending.
    a_reset_clean: assert property (@(posedge clk)
        rst |=> (mon.count == '0) && !mon.ovf)
        else $error("counter_chk: state not clean after reset");

    // A wrap can only land on zero (up) or all-ones (down).
    a_ovf_value: assert property (@(posedge clk)
        mon.ovf |-> (mon.count == '0) || (mon.count == '1))
        else $error("counter_chk: wrap flag with non-wrap count");

    // With no control active the count holds and no wrap is flagged.
    a_hold: assert property (@(posedge clk)
        (!rst && !mon.clr && !mon.load && !mon.en) |=>
            (mon.count == $past(mon.count)) && !mon.ovf)
        else $error("counter_chk: count moved while idle");

endmodule

// File: rtl/counter.sv
// counter: WIDTH-bit up/down counter with synchronous clear, parallel load
// and a one-cycle wrap flag.
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset (highest priority)
//   clr      synchronous clear to zero
//   en       step enable
//   down     direction, UP=0 increments, DOWN=1 decrements
//   load     synchronous load of load_val (zero-extended or truncated to WIDTH)
//   load_val 16-bit load value
//   count    current count, straight from a register
//   ovf      high for the single cycle after an up or down wrap
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              down,
    input  logic              load,
    input  logic [LOAD_W-1:0] load_val,
    output logic [WIDTH-1:0]  count,
    output logic              ovf
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] load_adj_s;
    cnt_op_e          op_s;

    // Fit the 16-bit load bus to the counter width.
    if (WIDTH > LOAD_W) begin : g_load_ext
        assign load_adj_s = {{(WIDTH - LOAD_W){1'b0}}, load_val};
    end else if (WIDTH == LOAD_W) begin : g_load_eq
        assign load_adj_s = load_val;
    end else begin : g_load_trunc
        assign load_adj_s = load_val[WIDTH-1:0];
    end

    assign op_s = sel_op(clr, load, en);

    // Next count and wrap flag, computed together so they register on the same edge.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        case (op_s)
            OP_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_LOAD: begin
                count_d = load_adj_s;
                ovf_d   = 1'b0;
            end
            OP_STEP: begin
                if (down == DOWN) begin
                    count_d = count_q - WIDTH'(1'b1);
                    ovf_d   = ~|count_q;
                end else begin
                    count_d = count_q + WIDTH'(1'b1);
                    ovf_d   = &count_q;
                end
            end
            OP_HOLD: begin
                count_d = count_q;
                ovf_d   = 1'b0;
            end
            default: begin
                count_d = count_q;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Count and wrap-flag registers; reset overrides every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: drives five counter instances (WIDTH 1, 4, 8, 20, 30) with the
// same stimulus; a modular-arithmetic model predicts each edge and a
// scoreboard queue feeds an independent monitor that compares on negedge.
module tb_counter;

    localparam int NW = 5;

    typedef struct packed {
        logic [NW-1:0][63:0] c;
        logic [NW-1:0]       o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        en;
    logic        down;
    logic        load;
    logic [15:0] load_val;

    logic [63:0] act_c [NW];
    logic        act_o [NW];

    exp_t   exp_q[$];
    int     n_tests;
    int     n_fail;
    int     ws [NW] = '{1, 4, 8, 20, 30};
    longint mdl_c [NW];
    bit     mdl_o [NW];

    for (genvar g = 0; g < NW; g++) begin : g_w
        localparam int W = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : (g == 3) ? 20 : 30;

        counter_if #(.WIDTH(W)) ifc ();

        assign ifc.clr      = clr;
        assign ifc.en       = en;
        assign ifc.down     = down;
        assign ifc.load     = load;
        assign ifc.load_val = load_val;

        counter #(.WIDTH(W)) dut (
            .clk      (clk),
            .rst      (rst),
            .clr      (ifc.clr),
            .en       (ifc.en),
            .down     (ifc.down),
            .load     (ifc.load),
            .load_val (ifc.load_val),
            .count    (ifc.count),
            .ovf      (ifc.ovf)
        );

        counter_chk u_chk (
            .clk (clk),
            .rst (rst),
            .mon (ifc.monitor)
        );

        assign act_c[g] = 64'(ifc.count);
        assign act_o[g] = ifc.ovf;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: count lives in the integers modulo 2^W; a wrap is a step
    // whose plain-integer result falls outside [0, 2^W).
    task automatic model_step();
        exp_t   x;
        longint m;
        longint nxt;
        for (int i = 0; i < NW; i++) begin
            m = longint'(1) << ws[i];
            mdl_o[i] = 1'b0;
            if (rst || clr) begin
                mdl_c[i] = 0;
            end else if (load) begin
                mdl_c[i] = longint'(load_val) % m;
            end else if (en) begin
                nxt = down ? mdl_c[i] - 1 : mdl_c[i] + 1;
                mdl_o[i] = (nxt < 0) || (nxt >= m);
                mdl_c[i] = (nxt + m) % m;
            end
            x.c[i] = 64'(mdl_c[i]);
            x.o[i] = mdl_o[i];
        end
        exp_q.push_back(x);
    endtask

    task automatic tick(input logic r, input logic c, input logic e,
                        input logic d, input logic l, input logic [15:0] lv);
        rst      = r;
        clr      = c;
        en       = e;
        down     = d;
        load     = l;
        load_val = lv;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        exp_t e;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clr      = 1'b0;
        en       = 1'b0;
        down     = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        for (int i = 0; i < NW; i++) begin
            mdl_c[i] = 0;
            mdl_o[i] = 1'b0;
        end

        // Scoreboard monitor: one popped entry per observed cycle.
        fork
            forever begin
                @(negedge clk);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < NW; i++) begin
                        n_tests++;
                        if (act_c[i] !== e.c[i]) begin
                            n_fail++;
                            $display("FAIL count W=%0d act=%0h exp=%0h t=%0t", ws[i], act_c[i], e.c[i], $time);
                        end
                        n_tests++;
                        if (act_o[i] !== e.o[i]) begin
                            n_fail++;
                            $display("FAIL ovf W=%0d act=%0b exp=%0b t=%0t", ws[i], act_o[i], e.o[i], $time);
                        end
                    end
                end
            end
        join_none

        // Reset with every other control active must still give zero.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);

        // 16 up-steps: 4-bit instance walks 1..15 then wraps to 0.
        for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Down-wrap from zero, then one more down-step.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Load truncation / zero extension.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // clr beats load; rst beats load.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0055);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055);

        // en toggled 1,0,1 from 0x10.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Reset on the edge that would have wrapped: no wrap flag afterwards.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Free-run 1024 edges from reset.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 1024; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        #1;
        n_tests++;
        if (act_c[4] !== 64'd1024) begin
            n_fail++;
            $display("FAIL freerun W=30 act=%0d exp=1024", act_c[4]);
        end

        // Randomized control mix, including direction changes while enabled.
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the count width in bits; legal range 1..64.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clr  input  1  synchronous clear of count to zero.
REQ-005 en  input  1  count enable, one step per clk while high.
REQ-006 down  input  1  direction: 0 = increment, 1 = decrement.
REQ-007 load  input  1  synchronous parallel load from load_val.
REQ-008 load_val  input  16  value loaded into count when load is high.
REQ-009 count  output  WIDTH  current count, driven directly from a register.
REQ-010 ovf  output  1  one-cycle registered wrap flag, overflow when counting up or underflow when counting down.
REQ-011 Port order SHALL be clk, rst, clr, en, down, load, load_val, count, ovf, so that positional instantiation binds correctly.

Function
REQ-012 All state SHALL update only on the rising edge of clk; there SHALL be no asynchronous paths.
REQ-013 Per-edge priority SHALL be rst, then clr, then load, then en; only the highest-priority active control takes effect.
REQ-014 When clr is high and rst is low, count SHALL become 0 and ovf SHALL become 0.
REQ-015 When load is high and rst and clr are low, count SHALL become load_val adjusted to WIDTH, and ovf SHALL become 0.
- WIDTH>16: load_val is zero-extended.
- WIDTH<16: only the low WIDTH bits are used.
REQ-016 When en is high, down is 0 and no higher-priority control is active, count SHALL become count+1 modulo 2^WIDTH.
REQ-017 When en is high, down is 1 and no higher-priority control is active, count SHALL become count-1 modulo 2^WIDTH.
REQ-018 Up-count wrap (count all-ones, en=1, down=0) SHALL set count to 0 and assert ovf for exactly the following cycle.
REQ-019 Down-count wrap (count 0, en=1, down=1) SHALL set count to all-ones and assert ovf for exactly the following cycle.
REQ-020 On every other edge ovf SHALL be 0, including hold cycles with en=0.
REQ-021 With en low and no other control active, count SHALL hold its value.
REQ-022 A change of down while en is high SHALL take effect on the next edge with no dead cycle.
REQ-023 Latency SHALL be one clk from any control input to count and ovf.
REQ-024 The counter SHALL free-run and wrap indefinitely with en tied high, load/clr/down tied low.
REQ-025 The WIDTH=1 case SHALL toggle count every enabled cycle and assert ovf on each 1->0 (up) or 0->1 (down) transition.

Reset
REQ-026 While rst is high at a clk edge, count SHALL become 0 and ovf SHALL become 0, regardless of the other inputs.
REQ-027 The first enabled edge after rst deasserts SHALL produce count = 1 when counting up, or all-ones when counting down.
REQ-028 Asserting rst mid-count SHALL abandon any pending wrap; ovf SHALL be 0 in the cycle after reset.

Structure
REQ-029 The block SHALL be one flat module with no sub-modules.
REQ-030 The shared package SHALL hold the LOAD_W = 16 constant and the direction encoding constants UP = 0, DOWN = 1.
REQ-031 The next-count value and the wrap detect SHALL be computed combinationally and registered together.

Verification
REQ-032 WIDTH=4: rst, then en=1, down=0 for 16 cycles -> count 1..15 then 0; ovf high only in the cycle count shows 0.
REQ-033 WIDTH=4: from count=0, en=1, down=1 for one cycle -> count=15, ovf=1 for one cycle; next edge -> 14, ovf=0.
REQ-034 WIDTH=4: load=1, load_val=16'h00AB -> count=4'hB. WIDTH=20: same load -> count=20'h000AB.
REQ-035 WIDTH=8: clr=1 and load=1 in the same cycle with count=8'h55 -> count=0; rst=1 with clr=0, load=1 -> count=0, ovf=0.
REQ-036 WIDTH=8: en toggled 1,0,1 from count=8'h10 -> 8'h11, hold 8'h11, then 8'h12; no ovf.
REQ-037 WIDTH=30 free-run from reset for 2^10 cycles -> count=1024, ovf never asserted.
